ac_motor_vf_ramp_control: RTL

Run-state controller for the AC motor space-vector pipeline. It owns the `frequency` and `u_str` inputs of the sine-sector and vector-time stages, and the gate-driver enable. From start, stop and fault commands it ramps the electrical frequency toward a commanded target at a fixed rate. It derives the voltage amplitude `u_str` from the current frequency using a V/f law with low-speed boost, and shuts the bridge down immediately on fault.

---
 rtl/ac_motor_vf_ramp_control.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ac_motor_vf_ramp_control.sv
// ac_motor_vf_ramp_control
// Run-state controller for the space-vector pipeline: ramps the electrical
// frequency toward a commanded target at a fixed rate, derives the voltage
// amplitude from a V/f law with low-speed boost, and gates the bridge.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, stop       run request / ramp-down request (stop also acks a fault)
//   fault             hardware fault level, highest priority
//   target_freq[11:0] commanded frequency, used combinationally every cycle
//   frequency[11:0]   current electrical frequency (to sine-sector stage)
//   u_str[11:0]       voltage amplitude (to vector-time stage)
//   pwm_enable        gate-driver enable
//   at_speed          high in RUN
//   state[2:0]        IDLE=0, RAMP=1, RUN=2, STOP=3, FAULT=4
module ac_motor_vf_ramp_control #(
    parameter int unsigned RAMP_DIV = 1000,
    parameter int unsigned STEP     = 1,
    parameter int unsigned BOOST    = 256,
    parameter int unsigned VF_NUM   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        fault,
    input  logic [11:0] target_freq,
    output logic [11:0] frequency,
    output logic [11:0] u_str,
    output logic        pwm_enable,
    output logic        at_speed,
    output logic [2:0]  state
);

    localparam int unsigned FW    = 12;
    localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RAMP  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [FW-1:0]    freq_q, freq_d;
    logic [FW-1:0]    ustr_q, ustr_d;
    logic             pwm_q, pwm_d;
    logic             at_q, at_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic [19:0]      vf_prod;
    logic [20:0]      vf_sum;

    // One STEP toward goal, landing exactly on goal when closer than STEP.
    function automatic logic [FW-1:0] step_toward(input logic [FW-1:0] cur,
                                                  input logic [FW-1:0] goal);
        logic [FW:0] diff;
        if (cur < goal) begin
            diff = (FW+1)'(goal) - (FW+1)'(cur);
            return (diff <= (FW+1)'(STEP)) ? goal : cur + FW'(STEP);
        end else if (cur > goal) begin
            diff = (FW+1)'(cur) - (FW+1)'(goal);
            return (diff <= (FW+1)'(STEP)) ? goal : cur - FW'(STEP);
        end
        return cur;
    endfunction

    assign tick = (cnt_q == CNT_W'(RAMP_DIV - 1));

    // V/f law on the registered frequency, so u_str lags frequency by one cycle.
    assign vf_prod = 20'(freq_q) * 20'(VF_NUM);
    assign vf_sum  = 21'(BOOST) + 21'(vf_prod >> 4);

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        cnt_d   = cnt_q;

        if (fault) begin
            state_d = S_FAULT;
            freq_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_d = S_RAMP;
                        cnt_d   = '0;
                    end
                end
                S_RAMP: begin
                    if (stop)                        state_d = S_STOP;
                    else if (freq_q == target_freq)  state_d = S_RUN;
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_STOP;
                        cnt_d   = '0;
                    end else if (freq_q != target_freq) begin
                        state_d = S_RAMP;
                        cnt_d   = '0;
                    end
                end
                S_STOP: begin
                    if (start && !stop)      state_d = S_RAMP;
                    else if (freq_q == '0)   state_d = S_IDLE;
                end
                S_FAULT: begin
                    freq_d = '0;
                    if (stop) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    freq_d  = '0;
                end
            endcase

            // Tick phase carries across RAMP<->STOP; the step follows the new direction.
            if ((state_q == S_RAMP || state_q == S_STOP) &&
                (state_d == S_RAMP || state_d == S_STOP)) begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                if (tick)
                    freq_d = step_toward(freq_q, (state_d == S_RAMP) ? target_freq : '0);
            end
        end

        pwm_d  = (state_d == S_RAMP) || (state_d == S_RUN) || (state_d == S_STOP);
        at_d   = (state_d == S_RUN);
        ustr_d = '0;
        if (pwm_d)
            ustr_d = (vf_sum > 21'd4095) ? 12'hFFF : vf_sum[FW-1:0];
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            freq_q  <= '0;
            ustr_q  <= '0;
            pwm_q   <= 1'b0;
            at_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            ustr_q  <= ustr_d;
            pwm_q   <= pwm_d;
            at_q    <= at_d;
            cnt_q   <= cnt_d;
        end
    end

    assign frequency  = freq_q;
    assign u_str      = ustr_q;
    assign pwm_enable = pwm_q;
    assign at_speed   = at_q;
    assign state      = state_q;

endmodule
